dmem_arbiter: RTL and testbench

- Arbitrates the single-port data memory between the pipeline MEM stage (CPU port) and an auxiliary requester (loader/DMA/debug, AUX port).
- Sequences each access as a variable-latency req/ack transaction.
- Generates the pipeline stall that freezes F/D/E/M while a MEM access is outstanding.
- Keeps a saturating stall-cycle counter that feeds CPI accounting.

---
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: grants the single memory port to the CPU MEM stage or an
// AUX requester, sequences req/ack with timeout, and drives the pipeline stall.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              aux_valid,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              aux_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CPU, AUX} state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic [TW-1:0] timer;
  logic          pulse, cpu_elig, aux_elig, grant_cpu, grant_aux, expired;

  // No grant while any completion pulse is out: the finished requester has not
  // had a chance to withdraw yet.
  always_comb begin
    pulse     = cpu_done | aux_ready;
    cpu_elig  = cpu_req & ~pulse;
    aux_elig  = aux_valid & ~pulse;
    grant_cpu = (state == IDLE) && cpu_elig && (!aux_elig || (streak < SW'(MAX_STREAK)));
    grant_aux = (state == IDLE) && aux_elig && !grant_cpu;
    expired   = (timer == TW'(TIMEOUT - 1));
    cpu_stall = cpu_req & ~cpu_done & ~reset;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      streak       <= '0;
      timer        <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_done     <= 1'b0;
      aux_ready    <= 1'b0;
      cpu_rdata    <= '0;
      aux_rdata    <= '0;
      bus_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      cpu_done  <= 1'b0;
      aux_ready <= 1'b0;
      if (cpu_stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;

      case (state)
        IDLE: begin
          if (grant_cpu) begin
            state     <= CPU;
            mem_req   <= 1'b1;
            mem_we    <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            timer     <= '0;
            if (!aux_valid)
              streak <= '0;
            else if (streak != SW'(MAX_STREAK))
              streak <= streak + 1'b1;
          end else if (grant_aux) begin
            state     <= AUX;
            mem_req   <= 1'b1;
            mem_we    <= aux_we;
            mem_addr  <= aux_addr;
            mem_wdata <= aux_wdata;
            timer     <= '0;
            streak    <= '0;
          end
        end
        CPU, AUX: begin
          if (mem_ack || expired) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (!mem_ack)
              bus_err <= 1'b1;
            // Timeout forces rdata to zero; a write ack keeps the old value.
            if (state == CPU) begin
              cpu_done <= 1'b1;
              if (!mem_ack)     cpu_rdata <= '0;
              else if (!mem_we) cpu_rdata <= mem_rdata;
            end else begin
              aux_ready <= 1'b1;
              if (!mem_ack)     aux_rdata <= '0;
              else if (!mem_we) aux_rdata <= mem_rdata;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboarded random bench for dmem_arbiter with a behavioural memory and
// per-port reference model over disjoint CPU / AUX address regions.
module tb_dmem_arbiter;
  localparam int AW = 32, DW = 32, MS = 4, TO = 8, CW = 32;

  logic          clk, rst;
  logic          cpu_req, cpu_we, cpu_done, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          aux_valid, aux_we, aux_ready;
  logic [AW-1:0] aux_addr;
  logic [DW-1:0] aux_wdata, aux_rdata;
  logic          mem_req, mem_we, mem_ack, bus_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [CW-1:0] stall_cycles;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MS), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .aux_valid(aux_valid), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_rdata(aux_rdata), .aux_ready(aux_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    bit          tmo;
  } txn_t;

  txn_t        cpu_q[$], aux_q[$];
  int          grant_log[$];
  bit          log_en;
  int          total, bad;
  logic [31:0] cpu_model[64], aux_model[64], mem_c[64], mem_a[64];
  logic [31:0] cpu_last, aux_last;
  bit          exp_err;
  int unsigned exp_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 255;      // never acked: forces timeout
    if (r == 1) return TO - 1;   // ack on the last allowed cycle
    return $urandom_range(0, 3);
  endfunction

  // Issue one transaction on a port (called at a negedge) and wait for its completion.
  task automatic run(input bit port, input logic we, input int idx, input logic [31:0] wd,
                     input int lat, input bit exact);
    txn_t t;
    int   n;
    bit   prev_done, prev_pulse;
    t.we    = we;
    t.addr  = (port ? 32'h200 : 32'h0) + 32'(idx * 4);
    t.wdata = wd;
    t.lat   = lat;
    t.tmo   = (lat >= TO);
    if (port == 0) begin
      t.rdata = t.tmo ? 32'h0 : (we ? cpu_last : cpu_model[idx]);
      if (we && !t.tmo) cpu_model[idx] = wd;
      cpu_last = t.rdata;
      cpu_q.push_back(t);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = t.addr; cpu_wdata = wd;
    end else begin
      t.rdata = t.tmo ? 32'h0 : (we ? aux_last : aux_model[idx]);
      if (we && !t.tmo) aux_model[idx] = wd;
      aux_last = t.rdata;
      aux_q.push_back(t);
      aux_valid = 1'b1; aux_we = we; aux_addr = t.addr; aux_wdata = wd;
    end
    prev_done  = cpu_done;
    prev_pulse = cpu_done | aux_ready;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(port ? aux_ready : cpu_done) && n < 200);
    chk(port ? "aux_ready_seen" : "cpu_done_seen", port ? aux_ready : cpu_done, 1);
    if (exact)
      chk(port ? "aux_latency" : "cpu_latency", n - int'(prev_pulse), t.tmo ? TO + 1 : lat + 2);
    if (port == 0) begin
      exp_stall += n - int'(prev_done);
      chk("stall_cycles", stall_cycles, exp_stall);
    end else if (exact) begin
      chk("stall_cycles_aux", stall_cycles, exp_stall);
    end
  endtask

  task automatic idle(input bit port, input int k);
    if (port == 0) cpu_req = 1'b0; else aux_valid = 1'b0;
    for (int i = 0; i < k; i++) begin
      if (port == 0) begin cpu_addr = $urandom; cpu_wdata = $urandom; cpu_we = 1'($urandom); end
      else begin aux_addr = $urandom; aux_wdata = $urandom; aux_we = 1'($urandom); end
      @(negedge clk);
    end
  endtask

  // Memory responder: acks after the latency chosen by the issuing driver.
  initial begin
    int   cnt;
    bit   port;
    txn_t h;
    cnt = 0; mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0; mem_ack = 1'b0;
      end else if (mem_req) begin
        port = mem_addr[9];
        chk("mem_req_has_txn", port ? (aux_q.size() != 0) : (cpu_q.size() != 0), 1);
        if (port ? aux_q.size() != 0 : cpu_q.size() != 0) begin
          h = port ? aux_q[0] : cpu_q[0];
          if (cnt == 0 && log_en) grant_log.push_back(int'(port));
          chk("mem_we", mem_we, h.we);
          chk("mem_addr", mem_addr, h.addr);
          if (h.we) chk("mem_wdata", mem_wdata, h.wdata);
          chk("mem_req_len", cnt < TO, 1);
          mem_rdata = $urandom;
          if (cnt == h.lat) begin
            mem_ack = 1'b1;
            if (mem_we) begin
              if (port) mem_a[mem_addr[7:2]] = mem_wdata; else mem_c[mem_addr[7:2]] = mem_wdata;
            end else begin
              mem_rdata = port ? mem_a[mem_addr[7:2]] : mem_c[mem_addr[7:2]];
            end
          end else begin
            mem_ack = 1'b0;
          end
        end else begin
          mem_ack = 1'b0;
        end
        cnt++;
      end else begin
        cnt = 0;
        mem_ack = ($urandom_range(0, 7) == 0);  // stray ack outside a transaction
        mem_rdata = $urandom;
      end
    end
  end

  // Completion monitor: pops the scoreboard whenever a port pulses.
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cpu_done) begin
          chk("cpu_done_expected", cpu_q.size() != 0, 1);
          if (cpu_q.size() != 0) begin
            t = cpu_q.pop_front();
            chk("cpu_rdata", cpu_rdata, t.rdata);
            if (t.tmo) exp_err = 1'b1;
          end
          chk("bus_err_cpu", bus_err, exp_err);
        end
        if (aux_ready) begin
          chk("aux_ready_expected", aux_q.size() != 0, 1);
          if (aux_q.size() != 0) begin
            t = aux_q.pop_front();
            chk("aux_rdata", aux_rdata, t.rdata);
            if (t.tmo) exp_err = 1'b1;
          end
          chk("bus_err_aux", bus_err, exp_err);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    total = 0; bad = 0; exp_err = 0; exp_stall = 0; log_en = 0;
    cpu_last = '0; aux_last = '0;
    foreach (cpu_model[i]) begin cpu_model[i] = '0; aux_model[i] = '0; mem_c[i] = '0; mem_a[i] = '0; end
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    aux_valid = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0;
    #3;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_cpu_done", cpu_done, 0);
    chk("rst_aux_ready", aux_ready, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_aux_rdata", aux_rdata, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_stall_cycles", stall_cycles, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // CPU alone: store 25 to 100, load it back after two wait cycles, then random.
    run(0, 1'b1, 25, 32'd25, 0, 1);
    idle(0, 1);
    run(0, 1'b0, 25, 32'h0, 2, 1);
    idle(0, 1);
    for (int i = 0; i < 20; i++) begin
      run(0, 1'($urandom), $urandom_range(20, 30), $urandom, pick_lat(), 1);
      if ($urandom_range(0, 1) == 1) idle(0, $urandom_range(1, 2));
    end
    idle(0, 2);

    // AUX alone: first a write to 0x200, cpu_stall must never rise.
    run(1, 1'b1, 0, 32'hA5A5_A5A5, 1, 1);
    for (int i = 0; i < 12; i++) begin
      run(1, 1'($urandom), $urandom_range(0, 5), $urandom, pick_lat(), 1);
      if ($urandom_range(0, 1) == 1) idle(1, 1);
    end
    idle(1, 2);

    // Both held continuously, zero-wait memory: starvation guard ordering.
    grant_log.delete();
    log_en = 1;
    fork
      begin
        for (int i = 0; i < 8; i++) run(0, 1'($urandom), $urandom_range(0, 63), $urandom, 0, 0);
        idle(0, 1);
      end
      begin
        for (int i = 0; i < 2; i++) run(1, 1'($urandom), $urandom_range(0, 63), $urandom, 0, 0);
        idle(1, 1);
      end
    join
    log_en = 0;
    chk("grant_count", grant_log.size(), 10);
    for (int i = 0; i < grant_log.size() && i < 10; i++)
      chk($sformatf("grant_order_%0d", i), grant_log[i], (i % 5 == 4) ? 1 : 0);
    idle(0, 2);

    // Concurrent random traffic.
    fork
      for (int i = 0; i < 30; i++) begin
        run(0, 1'($urandom), $urandom_range(0, 63), $urandom, pick_lat(), 0);
        idle(0, $urandom_range(0, 2));
      end
      for (int i = 0; i < 30; i++) begin
        run(1, 1'($urandom), $urandom_range(0, 63), $urandom, pick_lat(), 0);
        idle(1, $urandom_range(0, 2));
      end
    join
    idle(0, 3);

    // Asynchronous reset in the middle of a long transaction.
    t.we = 0; t.addr = 32'h40; t.wdata = 0; t.lat = 255; t.tmo = 1; t.rdata = 0;
    cpu_q.push_back(t);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    repeat (3) @(negedge clk);
    chk("pre_rst_mem_req", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mem_req", mem_req, 0);
    chk("async_rst_cpu_stall", cpu_stall, 0);
    chk("async_rst_bus_err", bus_err, 0);
    chk("async_rst_stall_cycles", stall_cycles, 0);
    cpu_q.delete(); aux_q.delete();
    cpu_req = 0; exp_stall = 0; exp_err = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_no_done", {cpu_done, aux_ready, mem_req}, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
